pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Control-side driver for the per-stage en/squash pipeline registers. It tracks one valid bit per register, resolves stall back-pressure and squash requests, and produces the en[] and squash[] vectors that a DEPTH-stage pipe register bank consumes. It inserts bubbles (squash) wherever a register advances without fresh data, so no duplicated payload travels downstream. It sits beside each vector-lane datapath pipe, between issue (upstream) and writeback (downstream).

Parameters:
DEPTH, 4, number of pipeline registers controlled (>=1); bit i = register i, register 0 nearest the input.
OCC_W, 3, width of occupancy output; must be >= clog2(DEPTH+1).

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  synchronous active-low reset
in_valid  input  1  upstream presents an item this cycle
in_ready  output  1  item is accepted into register 0 this cycle
stall_req  input  DEPTH  stage i requests its register to hold
squash_req  input  DEPTH  kill the content of, and any item entering, register i
flush  input  1  kill all registers and the entering item
out_ready  input  1  downstream consumes register DEPTH-1
out_valid  output  1  = valid[DEPTH-1]
en  output  DEPTH  register enables to the pipe bank
squash  output  DEPTH  register clears to the pipe bank
valid  output  DEPTH  registered valid bits
busy  output  1  OR of valid
occupancy  output  OCC_W  popcount of valid

Behaviour:
- State: valid[DEPTH-1:0] only; everything else is combinational from state and inputs.
- Reset (resetn=0 at edge): valid<=0. While resetn=0: en=0, squash=all ones, in_ready=0; out_valid, busy, occupancy follow valid (0 after first reset edge).
- Hold chain, evaluated from the output end:
  - hold[DEPTH-1] = valid[DEPTH-1] & (stall_req[DEPTH-1] | ~out_ready)
  - hold[i] = valid[i] & (stall_req[i] | hold[i+1])
  - (see Optional Feature for the valid term)
- en[i] = ~hold[i].
- Source valid:
  - src[0] = in_valid & ~flush
  - src[i] = valid[i-1] & ~hold[i-1]
  - A held upstream register never feeds downstream.
- squash[i] = flush | squash_req[i] | (en[i] & ~src[i]). The third term inserts a bubble instead of duplicating data.
- Next state:
  - valid[i] <= 0 if squash[i]
  - else src[i] if en[i]
  - else unchanged
- Squash vs hold: squash wins. A held register that is squashed is cleared. Squash does not release upstream holds in the same cycle.
- in_ready = ~hold[0] & ~squash_req[0] & ~flush. An item is accepted iff in_valid & in_ready.
- Output handshake: an item leaves when out_valid & out_ready & ~stall_req[DEPTH-1]. out_valid may rise with out_ready low and stays high until consumed or squashed.
- Latency: an accepted item with no stalls reaches out_valid DEPTH cycles after acceptance; throughput is 1 item/cycle.
- Full pipe (occupancy=DEPTH) with out_ready=1 and no stalls still accepts every cycle.
- Reset mid-operation discards all items; no partial state survives.

Optional Feature:
PIPE_CTRL_BUBBLE_COLLAPSE_EN.
- Defined: hold terms include valid[i] as written, so an empty register keeps loading while downstream holds, and bubbles are squeezed out.
- Undefined: hold[i] = stall_req[i] | hold[i+1] with hold[DEPTH-1] = stall_req[DEPTH-1] | ~out_ready, so the whole pipe freezes on any stall regardless of valid. Smaller logic; all other rules are unchanged.

Test Plan:
1. DEPTH=4, reset, then in_valid=1 and out_ready=1 held: first cycle en=4'b1111, squash=4'b1110. valid goes 0001, 0011, 0111, 1111. out_valid=1 on the 4th edge after first acceptance; squash=0000 once full.
2. valid=4'b1111, out_ready=0: en=4'b0000, squash=4'b0000, in_ready=0, valid stays 1111 for the whole stall. out_ready=1 resumes 1 item/cycle.
3. valid=4'b1111, out_ready=1, stall_req=4'b0010 for one cycle: en=4'b1100, squash=4'b0100, in_ready=0, next valid=4'b1011.
4. valid=4'b1101, out_ready=0, in_valid=1:
   - With macro: en=4'b0011, squash=0000, in_ready=1, next valid=4'b1111.
   - Without macro: en=4'b0000, in_ready=0, valid unchanged.
5. valid=4'b1111, in_valid=1, flush=1: squash=4'b1111, in_ready=0, next valid=0000, busy=0 and occupancy=0 the following cycle.
6. valid=4'b0111, resetn=0 for one edge with in_valid=1: squash=4'b1111, en=0000, next valid=0000, out_valid=0. Normal fill resumes after resetn=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid/en/squash controller for a DEPTH-stage pipe register bank.
// Define PIPE_CTRL_BUBBLE_COLLAPSE_EN to let empty registers keep loading behind a stall.
module pipe_ctrl #(
    parameter int DEPTH = 4,
    parameter int OCC_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DEPTH-1:0] stall_req,
    input  logic [DEPTH-1:0] squash_req,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DEPTH-1:0] en,
    output logic [DEPTH-1:0] squash,
    output logic [DEPTH-1:0] valid,
    output logic             busy,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH:0]   hold;  // hold[DEPTH] stands for downstream back-pressure
    logic [DEPTH-1:0] src;
    logic [DEPTH-1:0] valid_nxt;

    always_comb begin
        // NOTE: every variable this block writes gets a default first, so no path infers a latch.
        hold      = '0;
        src       = '0;
        en        = '0;
        squash    = '0;
        in_ready  = 1'b0;
        valid_nxt = valid;

        hold[DEPTH] = ~out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
`ifdef PIPE_CTRL_BUBBLE_COLLAPSE_EN
            hold[i] = valid[i] & (stall_req[i] | hold[i+1]);
`else
            hold[i] = stall_req[i] | hold[i+1];
`endif
        end

        src[0] = in_valid & ~flush;
        for (int i = 1; i < DEPTH; i++) begin
            src[i] = valid[i-1] & ~hold[i-1];
        end

        // A register that advances without fresh data is cleared rather than duplicating payload.
        for (int i = 0; i < DEPTH; i++) begin
            en[i]     = ~hold[i];
            squash[i] = flush | squash_req[i] | (en[i] & ~src[i]);
        end
        in_ready = ~hold[0] & ~squash_req[0] & ~flush;

        if (!resetn) begin
            en       = '0;
            squash   = '1;
            in_ready = 1'b0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (squash[i])  valid_nxt[i] = 1'b0;
            else if (en[i]) valid_nxt[i] = src[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) valid <= '0;
        else         valid <= valid_nxt;
    end

    assign out_valid = valid[DEPTH-1];
    assign busy      = |valid;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid[i]);
        end
    end

endmodule
